alu_mul_sequencer: RTL and testbench

- Iterative shift-add multiplier controller that sequences one instance of the shared 32-bit ALU (alu_add only) to compute the low 32 bits of a 32x32 product (RV32M MUL semantics).
- Sits beside the execute-stage ALU; the pipeline stalls on req_ready/resp_valid.
- Valid/ready request and response handshakes, early termination, synchronous flush.

---
 rtl/rv32i_types.sv | 22 ++
 rtl/alu_mul_sequencer_if.sv | 20 ++
 rtl/alu.sv | 26 ++
 rtl/alu_mul_sequencer.sv | 89 ++++++++
 tb/tb_alu_mul_sequencer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: ALU operation encodings and the multiplier
// sequencer state, exported so hazard/stall logic can observe it.
package rv32i_types;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } mul_seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response handshake bundle between the pipeline and the multiplier.
interface alu_mul_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/alu.sv
// Shared 32-bit combinational ALU of the execute stage.
module alu
  import rv32i_types::*;
(
  input  alu_ops      aluop_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] f_o
);

  always_comb begin
    f_o = '0;
    unique case (aluop_i)
      alu_add: f_o = a_i + b_i;
      alu_sll: f_o = a_i << b_i[4:0];
      alu_sra: f_o = 32'($signed(a_i) >>> b_i[4:0]);
      alu_sub: f_o = a_i - b_i;
      alu_xor: f_o = a_i ^ b_i;
      alu_srl: f_o = a_i >> b_i[4:0];
      alu_or:  f_o = a_i | b_i;
      alu_and: f_o = a_i & b_i;
      default: f_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add multiplier (low 32 bits, RV32M MUL) that reuses one
// ALU instance for the accumulate step; shifts live in plain registers.
module alu_mul_sequencer
  import rv32i_types::*;
#(
  parameter int unsigned EARLY_TERM = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  output logic                       busy,
  alu_mul_sequencer_if.slave         bus
);

  mul_seq_state_t state_q, state_d;
  logic [31:0]    acc_q, acc_d;
  logic [31:0]    mcand_q, mcand_d;
  logic [31:0]    mplier_q, mplier_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [31:0]    alu_f;
  logic           last_iter;

  alu u_alu (
    .aluop_i (alu_add),
    .a_i     (acc_q),
    .b_i     (mcand_q),
    .f_o     (alu_f)
  );

  // Finish once no set multiplier bits remain beyond the one consumed now.
  assign last_iter = (cnt_q == 5'd31) || ((EARLY_TERM != 0) && (mplier_q[31:1] == '0));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            acc_d    = '0;
            mcand_d  = bus.req_a;
            mplier_d = bus.req_b;
            cnt_d    = '0;
            state_d  = StRun;
          end
        end
        StRun: begin
          if (mplier_q[0]) acc_d = alu_f;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          if (last_iter) state_d = StDone;
        end
        StDone: begin
          if (bus.resp_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StDone);
  assign bus.resp_data  = acc_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench: one early-terminating and one fixed-32-cycle multiplier.
module tb_alu_mul_sequencer;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy0;
  logic busy1;
  int   n_checks;
  int   n_fail;

  alu_mul_sequencer_if bus0 ();
  alu_mul_sequencer_if bus1 ();

  alu_mul_sequencer #(.EARLY_TERM(1)) u_dut_et (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy0),
    .bus   (bus0)
  );

  alu_mul_sequencer #(.EARLY_TERM(0)) u_dut_full (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy1),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op to the selected DUT, measure latency, check product, retire it.
  task automatic mul_op(input bit sel, input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data,
                        input int exp_lat);
    int lat;
    logic rv;
    if (sel) begin
      bus1.req_a = a; bus1.req_b = b; bus1.req_valid = 1'b1;
    end else begin
      bus0.req_a = a; bus0.req_b = b; bus0.req_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    bus1.req_valid = 1'b0;
    lat = 0;
    rv  = sel ? bus1.resp_valid : bus0.resp_valid;
    while (!rv && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      rv = sel ? bus1.resp_valid : bus0.resp_valid;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_data"}, sel ? bus1.resp_data : bus0.resp_data, exp_data);
    if (sel) bus1.resp_ready = 1'b1; else bus0.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.resp_ready = 1'b0;
    bus1.resp_ready = 1'b0;
    check_eq({tag, "_rdy"}, {31'b0, sel ? bus1.req_ready : bus0.req_ready}, 32'd1);
  endtask

  initial begin
    int   lat;
    logic seen;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_a = '0; bus0.req_b = '0; bus0.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_a = '0; bus1.req_b = '0; bus1.resp_ready = 1'b0;

    #2;
    check_eq("rst_req_ready", {31'b0, bus0.req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'b0, bus0.resp_valid}, 32'd0);
    check_eq("rst_resp_data", bus0.resp_data, 32'd0);
    check_eq("rst_busy", {31'b0, busy0}, 32'd0);
    check_eq("rst_busy_full", {31'b0, busy1}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    mul_op(1'b0, "basic", 32'd3, 32'd5, 32'd15, 3);
    mul_op(1'b0, "zero_b", 32'hDEADBEEF, 32'd0, 32'd0, 1);
    mul_op(1'b0, "zero_a", 32'd0, 32'h80000000, 32'd0, 32);
    mul_op(1'b0, "wrap_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
    mul_op(1'b0, "wrap_msb", 32'h80000000, 32'd2, 32'd0, 2);
    mul_op(1'b0, "signed", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 3);

    // Backpressure: hold the response for 10 cycles.
    bus0.req_a = 32'd7; bus0.req_b = 32'd6; bus0.req_valid = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    bus0.req_a = 32'd99; bus0.req_b = 32'd99;
    lat = 0;
    while (!bus0.resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp_valid", {31'b0, bus0.resp_valid}, 32'd1);
      check_eq("bp_data", bus0.resp_data, 32'd42);
      check_eq("bp_req_ready", {31'b0, bus0.req_ready}, 32'd0);
    end
    bus0.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.resp_ready = 1'b0;
    check_eq("bp_release", {31'b0, bus0.req_ready}, 32'd1);
    check_eq("bp_busy", {31'b0, busy0}, 32'd0);

    // Flush after the fifth RUN edge is pending.
    bus0.req_a = 32'h1234; bus0.req_b = 32'hFFFF; bus0.req_valid = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_idle", {31'b0, bus0.req_ready}, 32'd1);
    check_eq("flush_busy", {31'b0, busy0}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus0.resp_valid) seen = 1'b1;
    end
    check_eq("flush_no_resp", {31'b0, seen}, 32'd0);

    // Flush in IDLE blocks an accept.
    bus0.req_a = 32'd9; bus0.req_b = 32'd9; bus0.req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0; flush = 1'b0;
    check_eq("flush_idle_req", {31'b0, busy0}, 32'd0);
    mul_op(1'b0, "post_flush", 32'd2, 32'd3, 32'd6, 2);

    // Asynchronous reset between clock edges mid-RUN.
    bus0.req_a = 32'h1234; bus0.req_b = 32'hFFFF; bus0.req_valid = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_req_ready", {31'b0, bus0.req_ready}, 32'd1);
    check_eq("arst_busy", {31'b0, busy0}, 32'd0);
    check_eq("arst_resp_valid", {31'b0, bus0.resp_valid}, 32'd0);
    check_eq("arst_data", bus0.resp_data, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    mul_op(1'b1, "full_basic", 32'd3, 32'd5, 32'd15, 32);
    mul_op(1'b1, "full_zero", 32'hDEADBEEF, 32'd0, 32'd0, 32);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
